// File: rtl/tnoc_output_switch_pkg.sv
// Shared tnoc definitions: router configuration, flit layout, port count and counter width.
package tnoc_output_switch_pkg;

   localparam int unsigned TnocPorts      = 5;
   localparam int unsigned TnocCountWidth = 16;
   localparam int unsigned TnocVcWidth    = 2;
   localparam int unsigned TnocDataWidth  = 32;

   typedef struct packed {
      int unsigned virtual_channels;
      int unsigned data_width;
   } tnoc_config_t;

   localparam tnoc_config_t TNOC_DEFAULT_CONFIG = '{virtual_channels: 4, data_width: 32};

   typedef struct packed {
      logic                     head;
      logic                     tail;
      logic [TnocVcWidth-1:0]   vc;
      logic [TnocDataWidth-1:0] data;
   } tnoc_flit;

   typedef enum logic [0:0] {StIdle, StBusy} switch_state_e;

   function automatic logic is_onehot(logic [TnocPorts-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/tnoc_output_switch_if.sv
// Output-switch bundle: grant/free with the output port controller, per-port input flits and
// the single output flit stream. master = surrounding router, slave = the switch.
interface tnoc_output_switch_if;
   import tnoc_output_switch_pkg::*;

   logic [TnocPorts-1:0]      output_grant;
   logic                      output_free;
   logic [TnocPorts-1:0]      in_valid;
   logic [TnocPorts-1:0]      in_ready;
   tnoc_flit [TnocPorts-1:0]  in_flit;
   logic                      out_valid;
   logic                      out_ready;
   tnoc_flit                  out_flit;
   logic                      error;
   logic [TnocCountWidth-1:0] flit_count;

   modport master (
      output output_grant, in_valid, in_flit, out_ready,
      input  output_free, in_ready, out_valid, out_flit, error, flit_count
   );

   modport slave (
      input  output_grant, in_valid, in_flit, out_ready,
      output output_free, in_ready, out_valid, out_flit, error, flit_count
   );

endinterface

// File: rtl/tnoc_flit_slice.sv
// Two-entry output skid buffer (used when TNOC_OUTPUT_SWITCH_SLICE_EN is defined):
// full throughput, one cycle latency, outputs straight from flops.
module tnoc_flit_slice
   import tnoc_output_switch_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     in_valid,
   output logic     in_ready,
   input  tnoc_flit in_flit,
   output logic     out_valid,
   input  logic     out_ready,
   output tnoc_flit out_flit
);

   logic [1:0] cnt_q, cnt_d;
   tnoc_flit   head_q, head_d, skid_q, skid_d;
   logic       push, pop;

   assign in_ready  = (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign out_flit  = head_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      head_d = head_q;
      skid_d = skid_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = in_flit;
            else               skid_d = in_flit;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_d = skid_q;
            cnt_d  = cnt_q - 2'd1;
         end
         // push and pop together only happens with one entry held
         2'b11: head_d = in_flit;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         skid_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         skid_q <= skid_d;
      end
   end

endmodule

// File: rtl/tnoc_mux.sv
// One-hot select mux; callers guarantee sel is one-hot or zero (zero gives all-zero output).
module tnoc_mux #(
   parameter int unsigned Entries = 2,
   parameter type data_t = logic
) (
   input  logic [Entries-1:0]  sel,
   input  data_t [Entries-1:0] data,
   output data_t               out
);

   always_comb begin
      out = '0;
      for (int i = 0; i < Entries; i++) begin
         if (sel[i]) out = data[i];
      end
   end

endmodule

// File: rtl/tnoc_output_switch.sv
// Output switch: routes the granted input port to the output, tracks packet framing.
// Define TNOC_OUTPUT_SWITCH_SLICE_EN to register the output through tnoc_flit_slice.
module tnoc_output_switch
   import tnoc_output_switch_pkg::*;
#(
   parameter tnoc_config_t CONFIG = TNOC_DEFAULT_CONFIG
) (
   input logic                 clk,
   input logic                 rst_n,
   tnoc_output_switch_if.slave bus
);

   if (CONFIG.virtual_channels > (32'd1 << TnocVcWidth) ||
       CONFIG.data_width != TnocDataWidth) begin : g_config_check
      $error("tnoc_output_switch: CONFIG does not fit the tnoc_flit layout");
   end

   logic [TnocPorts-1:0]      grant, port_q, port_d;
   logic                      grant_onehot, grant_bad;
   logic                      can_accept, sel_valid, accept;
   tnoc_flit                  sel_flit;
   switch_state_e             state_q, state_d;
   logic [TnocCountWidth-1:0] count_q, count_d;
   logic                      clear_q, clear_d;

   assign grant        = bus.output_grant;
   assign grant_onehot = is_onehot(grant);
   assign grant_bad    = (grant != '0) && !grant_onehot;

   tnoc_mux #(.Entries(TnocPorts), .data_t(logic)) u_valid_mux (
      .sel  (grant),
      .data (bus.in_valid),
      .out  (sel_valid)
   );

   tnoc_mux #(.Entries(TnocPorts), .data_t(tnoc_flit)) u_flit_mux (
      .sel  (grant),
      .data (bus.in_flit),
      .out  (sel_flit)
   );

   assign bus.in_ready    = (rst_n && grant_onehot && can_accept) ? grant : '0;
   assign accept          = rst_n && grant_onehot && can_accept && sel_valid;
   assign bus.output_free = accept && sel_flit.tail;
   assign bus.flit_count  = count_q;

`ifdef TNOC_OUTPUT_SWITCH_SLICE_EN
   logic slice_ready;

   tnoc_flit_slice u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept),
      .in_ready  (slice_ready),
      .in_flit   (sel_flit),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_flit  (bus.out_flit)
   );

   assign can_accept = slice_ready;
`else
   assign can_accept    = bus.out_ready;
   assign bus.out_valid = rst_n && grant_onehot && sel_valid;
   assign bus.out_flit  = sel_flit;
`endif

   always_comb begin
      state_d   = state_q;
      port_d    = port_q;
      clear_d   = 1'b0;
      count_d   = clear_q ? '0 : count_q;
      bus.error = rst_n && grant_bad;
      if (rst_n && state_q == StBusy && grant != '0 && grant != port_q) bus.error = 1'b1;
      if (accept) begin
         if (sel_flit.head == (state_q == StBusy)) bus.error = 1'b1;
         if (sel_flit.head)         count_d = {{(TnocCountWidth-1){1'b0}}, 1'b1};
         else if (count_d != '1)    count_d = count_d + 1'b1;
         if (sel_flit.tail) begin
            state_d = StIdle;
            clear_d = 1'b1;
         end else if (sel_flit.head) begin
            state_d = StBusy;
            port_d  = grant;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         port_q  <= '0;
         count_q <= '0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         count_q <= count_d;
         clear_q <= clear_d;
      end
   end

endmodule

// File: tb/tb_tnoc_output_switch.sv
// Randomized scoreboard bench for tnoc_output_switch; works with or without
// TNOC_OUTPUT_SWITCH_SLICE_EN.
module tb_tnoc_output_switch;
   import tnoc_output_switch_pkg::*;

`ifdef TNOC_OUTPUT_SWITCH_SLICE_EN
   localparam bit Slice = 1'b1;
`else
   localparam bit Slice = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tnoc_output_switch_if bus ();

   tnoc_output_switch #(.CONFIG(TNOC_DEFAULT_CONFIG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0]  ready;
      logic        err;
      logic        free;
      logic [15:0] count;
      logic        valid;
   } ctl_t;

   ctl_t     ctl_q[$];
   tnoc_flit flit_q[$];
   int       errors = 0;
   int       checks = 0;

   // Reference model: packet framing in plain terms.
   bit m_in_packet;
   int m_owner;
   int m_len;
   bit m_ended;
   bit last_acc;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic tnoc_flit rand_flit();
      tnoc_flit f;
      f.head = 1'($urandom);
      f.tail = 1'($urandom);
      f.vc   = 2'($urandom);
      f.data = $urandom;
      return f;
   endfunction

   function automatic tnoc_flit make_flit(bit head, bit tail);
      tnoc_flit f;
      f      = rand_flit();
      f.head = head;
      f.tail = tail;
      return f;
   endfunction

   // Called just after a rising edge with inputs applied; queues expectations for this cycle.
   task automatic cycle();
      ctl_t       c;
      logic [4:0] g;
      int         p;
      bit         onehot, room, acc;
      tnoc_flit   f;
      g      = bus.output_grant;
      onehot = ($countones(g) == 1);
      p      = 0;
      for (int i = 0; i < 5; i++) if (g[i]) p = i;
      f        = bus.in_flit[p];
      last_acc = 1'b0;
      if (!rst_n) begin
         c.ready = '0; c.err = 1'b0; c.free = 1'b0; c.count = '0; c.valid = 1'b0;
         flit_q.delete();
         m_in_packet = 0; m_owner = 0; m_len = 0; m_ended = 0;
      end else begin
         room    = Slice ? (flit_q.size() < 2) : bus.out_ready;
         acc     = onehot && room && bus.in_valid[p];
         c.ready = (onehot && room) ? g : 5'd0;
         c.err   = (g != 0 && !onehot) ||
                   (m_in_packet && g != 0 && g != (5'd1 << m_owner)) ||
                   (acc && f.head && m_in_packet) || (acc && !f.head && !m_in_packet);
         c.free  = acc && f.tail;
         c.count = 16'(m_len);
         c.valid = Slice ? (flit_q.size() != 0) : (onehot && bus.in_valid[p]);
         if (acc) begin
            flit_q.push_back(f);
            last_acc = 1'b1;
            if (f.head) m_len = 1;
            else        m_len = ((m_ended ? 0 : m_len) + 1 > 65535) ? 65535
                                                                  : (m_ended ? 0 : m_len) + 1;
            m_ended = f.tail;
            if (f.tail) m_in_packet = 0;
            else if (f.head) begin
               m_in_packet = 1;
               m_owner     = p;
            end
         end else if (m_ended) begin
            m_len   = 0;
            m_ended = 0;
         end
      end
      ctl_q.push_back(c);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [4:0] g, logic [4:0] v, logic r, tnoc_flit fl);
      for (int i = 0; i < 5; i++) bus.in_flit[i] = g[i] ? fl : rand_flit();
      bus.output_grant = g;
      bus.in_valid     = v;
      bus.out_ready    = r;
      cycle();
   endtask

   // mode 0: ready always; 1: random ready/valid; 2: ready low for the first 5 cycles
   task automatic run_packet(int port, int len, int mode);
      int       sent = 0;
      int       n    = 0;
      logic     r, v;
      tnoc_flit fl;
      fl = make_flit(1'b1, len == 1);
      while (sent < len && n < 300) begin
         r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : (n >= 5);
         v = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         drive(5'd1 << port, 5'($urandom) & ~(5'd1 << port) | (5'(v) << port), r, fl);
         if (last_acc) begin
            sent++;
            fl = make_flit(1'b0, sent == len - 1);
         end
         n++;
      end
      if (sent < len) begin
         checks++;
         errors++;
         $display("FAIL packet_timeout: got %0d flits expected %0d", sent, len);
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(5'd0, 5'd0, 1'b1, rand_flit());
   endtask

   ctl_t     mc;
   tnoc_flit prev_flit;
   bit       prev_stall = 1'b0;

   always @(negedge clk) begin
      if (ctl_q.size() != 0) begin
         mc = ctl_q.pop_front();
         check("in_ready",    64'(bus.in_ready),    64'(mc.ready));
         check("error",       64'(bus.error),       64'(mc.err));
         check("output_free", 64'(bus.output_free), 64'(mc.free));
         check("flit_count",  64'(bus.flit_count),  64'(mc.count));
         check("out_valid",   64'(bus.out_valid),   64'(mc.valid));
      end
      if (bus.out_valid && bus.out_ready) begin
         if (flit_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_flit: got unexpected flit %0h expected none", bus.out_flit);
         end else begin
            check("out_flit", 64'(bus.out_flit), 64'(flit_q.pop_front()));
         end
      end
`ifdef TNOC_OUTPUT_SWITCH_SLICE_EN
      if (prev_stall && bus.out_valid) check("out_hold", 64'(bus.out_flit), 64'(prev_flit));
`endif
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_flit  = bus.out_flit;
   end

   initial begin
      rst_n            = 1'b0;
      bus.output_grant = '0;
      bus.in_valid     = '0;
      bus.in_flit      = '0;
      bus.out_ready    = 1'b0;
      @(posedge clk);
      #1;
      drive(5'b00100, 5'b11111, 1'b1, make_flit(1'b1, 1'b1));
      idle(1);
      rst_n = 1'b1;
      idle(1);

      run_packet(2, 1, 0);              // single-flit packet
      idle(2);
      run_packet(0, 4, 0);              // 4-flit packet, count 1..4 then 0
      idle(2);
      run_packet(1, 4, 2);              // downstream stall
      idle(3);
      drive(5'b00011, 5'b11111, 1'b1, make_flit(1'b1, 1'b1));   // bad grant
      idle(1);

      // framing violations
      drive(5'b01000, 5'b01000, 1'b1, make_flit(1'b0, 1'b0));   // body in idle
      drive(5'b01000, 5'b01000, 1'b1, make_flit(1'b1, 1'b0));
      drive(5'b01000, 5'b01000, 1'b1, make_flit(1'b0, 1'b0));
      drive(5'b01000, 5'b01000, 1'b1, make_flit(1'b1, 1'b0));   // head while busy
      drive(5'b10000, 5'b10000, 1'b1, make_flit(1'b0, 1'b0));   // grant switch mid-packet
      drive(5'b01000, 5'b01000, 1'b1, make_flit(1'b0, 1'b1));
      idle(3);

      // reset after 2 of 4 flits
      drive(5'b00001, 5'b00001, 1'b1, make_flit(1'b1, 1'b0));
      drive(5'b00001, 5'b00001, 1'b1, make_flit(1'b0, 1'b0));
      rst_n = 1'b0;
      drive(5'b00001, 5'b00001, 1'b1, make_flit(1'b0, 1'b0));
      rst_n = 1'b1;
      run_packet(3, 3, 0);
      idle(2);

      for (int k = 0; k < 60; k++) begin
         run_packet($urandom_range(0, 4), $urandom_range(1, 6), 1);
         if ($urandom_range(0, 5) == 0)
            drive(5'b11000, 5'($urandom), 1'($urandom), rand_flit());
         idle($urandom_range(0, 2));
      end

      idle(4);
      check("drain", 64'(flit_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
